// File: rtl/div3_seq_ctrl.sv
// div3_seq_ctrl: sequential unsigned divide-by-3 of a 16-bit operand.
// One radix-4 step per cycle, MSB digit first, valid/ready on both sides.
// Optional feature macro: DIV3_SKIP_LEADING_ZERO_EN (skip leading zero digits).
module div3_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [1:0]  remainder,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_shift;
    logic [15:0] r_quot;
    logic [1:0]  r_rem;
    logic [3:0]  r_cnt;

    logic        w_accept;
    logic [1:0]  w_qd;
    logic [1:0]  w_rd;
    logic [15:0] w_load_shift;
    logic [3:0]  w_load_cnt;

    assign w_accept  = in_valid & in_ready;
    assign quotient  = r_quot;
    assign remainder = r_rem;

    // Radix-4 step: v = 4*rem + digit, q = v/3, r = v mod 3 (rem=3 never occurs)
    always_comb begin
        w_qd = '0;
        w_rd = '0;
        case ({r_rem, r_shift[15:14]})
            4'd0:  begin w_qd = 2'd0; w_rd = 2'd0; end
            4'd1:  begin w_qd = 2'd0; w_rd = 2'd1; end
            4'd2:  begin w_qd = 2'd0; w_rd = 2'd2; end
            4'd3:  begin w_qd = 2'd1; w_rd = 2'd0; end
            4'd4:  begin w_qd = 2'd1; w_rd = 2'd1; end
            4'd5:  begin w_qd = 2'd1; w_rd = 2'd2; end
            4'd6:  begin w_qd = 2'd2; w_rd = 2'd0; end
            4'd7:  begin w_qd = 2'd2; w_rd = 2'd1; end
            4'd8:  begin w_qd = 2'd2; w_rd = 2'd2; end
            4'd9:  begin w_qd = 2'd3; w_rd = 2'd0; end
            4'd10: begin w_qd = 2'd3; w_rd = 2'd1; end
            4'd11: begin w_qd = 2'd3; w_rd = 2'd2; end
            default: begin w_qd = '0; w_rd = '0; end
        endcase
    end

`ifdef DIV3_SKIP_LEADING_ZERO_EN
    logic [3:0] w_lz;
    logic       w_found;

    // Count leading all-zero digits; those contribute q=0, r=0 and are pre-shifted away
    always_comb begin
        w_lz    = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!w_found && (dividend[15 - 2*i -: 2] == 2'b00)) begin
                w_lz = w_lz + 4'd1;
            end else begin
                w_found = 1'b1;
            end
        end
        w_load_shift = dividend << {w_lz, 1'b0};
        w_load_cnt   = 4'd8 - w_lz;
    end
`else
    // Full-length run: all 8 digits processed
    always_comb begin
        w_load_shift = dividend;
        w_load_cnt   = 4'd8;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_load_cnt == 4'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs, decoded from the state register only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_RUN:  busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath: load on accept, one digit per RUN cycle, hold in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= w_load_shift;
                        r_quot  <= '0;
                        r_rem   <= '0;
                        r_cnt   <= w_load_cnt;
                    end
                end
                S_RUN: begin
                    r_quot  <= {r_quot[13:0], w_qd};
                    r_rem   <= w_rd;
                    r_shift <= {r_shift[13:0], 2'b00};
                    r_cnt   <= r_cnt - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div3_seq_ctrl.sv
// Directed self-checking bench for div3_seq_ctrl.
// Latency expectations follow DIV3_SKIP_LEADING_ZERO_EN when it is defined.
module tb_div3_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [1:0]  remainder;
    logic        busy;

    int total = 0;
    int bad   = 0;

    div3_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int k);
`ifdef DIV3_SKIP_LEADING_ZERO_EN
        return 9 - k;
`else
        return 9;
`endif
    endfunction

    // One operation: accept, measure latency, check result, optionally back-pressure
    task automatic do_op(input string tag, input logic [15:0] d, input logic [15:0] eq,
                         input logic [1:0] er, input int k, input int hold);
        int lat;
        check({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        dividend  = d;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        dividend  = 16'hDEAD;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"},  32'(lat),       32'(exp_lat(k)));
        check({tag, ".quotient"}, 32'(quotient),  32'(eq));
        check({tag, ".remainder"},32'(remainder), 32'(er));
        check({tag, ".busy"},     32'(busy),      32'd1);
        check({tag, ".in_ready"}, 32'(in_ready),  32'd0);
        if (hold > 0) begin
            for (int c = 0; c < hold; c++) begin
                in_valid = 1'b1;
                dividend = 16'h0BAD;
                @(posedge clk); #1;
                check({tag, ".bp_valid"}, 32'(out_valid), 32'd1);
                check({tag, ".bp_quot"},  32'(quotient),  32'(eq));
                check({tag, ".bp_rem"},   32'(remainder), 32'(er));
                check({tag, ".bp_ready"}, 32'(in_ready),  32'd0);
            end
            // handoff edge with in_valid still high: must not be accepted
            out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({tag, ".bubble_busy"}, 32'(busy), 32'd0);
        end else begin
            @(posedge clk); #1;
        end
        check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".post_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        check("rst.quotient",  32'(quotient),  32'd0);
        check("rst.remainder", 32'(remainder), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("ffff", 16'hFFFF, 16'h5555, 2'd0, 0, 0);
        do_op("d100", 16'd100,  16'h0021, 2'd1, 4, 0);
        do_op("fffe", 16'hFFFE, 16'h5554, 2'd2, 0, 0);
        do_op("d5",   16'd5,    16'h0001, 2'd2, 6, 0);
        do_op("zero", 16'd0,    16'h0000, 2'd0, 8, 0);
        do_op("bp7",  16'd7,    16'h0002, 2'd1, 6, 5);
        do_op("d29k", 16'd29999,16'd9999, 2'd2, 0, 0);

        // reset on the 4th RUN cycle of 0x1234
        check("mid.in_ready_pre", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("mid.no_valid", 32'(out_valid), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid.in_ready",  32'(in_ready),  32'd1);
        check("mid.out_valid", 32'(out_valid), 32'd0);
        check("mid.busy",      32'(busy),      32'd0);
        check("mid.quotient",  32'(quotient),  32'd0);
        check("mid.remainder", 32'(remainder), 32'd0);
        repeat (10) begin
            @(posedge clk); #1;
            check("mid.stay_idle", 32'(out_valid), 32'd0);
        end

        do_op("d9", 16'd9, 16'h0003, 2'd0, 6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
